// File: rtl/seq_scan_pkg.sv
// Shared types and width helpers for the serial pattern-scan controller.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } scan_state_t;

  // Match counter must hold W-N+1 at most; W+1 values is a safe bound.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int pos_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_shift_match.sv
// N-bit history shift register with a fill counter that keeps bits from before
// the current word from ever producing a match.
module seq_shift_match #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         bit_in,
  input  logic [N-1:0] pattern,
  output logic         match
);

  localparam int FW = $clog2(N + 1);

  logic [N-1:0]  history;
  logic [N-1:0]  history_next;
  logic [FW-1:0] fill;

  assign history_next = {history[N-2:0], bit_in};

  // Compare on the next history so the match lines up with the shifting edge;
  // fill >= N-1 means the incoming bit completes N bits of the current word.
  assign match = shift_en && (fill >= FW'(N - 1)) && (history_next == pattern);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      history <= '0;
      fill    <= '0;
    end else if (clear) begin
      history <= '0;
      fill    <= '0;
    end else if (shift_en) begin
      history <= history_next;
      if (fill != FW'(N)) fill <= fill + FW'(1);
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-bit sequencer: accepts a word, scans it MSB-first through
// seq_shift_match, and reports match count / found / first position.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int N  = 6,
  parameter int W  = 32,
  parameter int CW = count_width(W),
  parameter int PW = pos_width(W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [N-1:0]      cfg_seq,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_count,
  output logic              out_found,
  output logic [PW-1:0]     out_first_pos,
  output logic              busy,
  output scan_state_t       debug_state
);

  localparam logic [PW-1:0] LAST_IDX = PW'(W - 1);

  scan_state_t   state;
  logic [N-1:0]  pattern;
  logic [W-1:0]  word;
  logic [PW-1:0] bit_idx;
  logic          accept;
  logic          shift_en;
  logic          match;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready depends only on state, and out_valid/outputs hold
  // steady until out_ready is seen.
  assign in_ready    = (state == IDLE);
  assign accept      = in_ready && in_valid;
  assign shift_en    = (state == SHIFT) && !abort;
  assign debug_state = state;

  seq_shift_match #(.N(N)) u_match (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (accept),
    .shift_en (shift_en),
    .bit_in   (word[W-1]),
    .pattern  (pattern),
    .match    (match)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pattern       <= '0;
      word          <= '0;
      bit_idx       <= '0;
      out_count     <= '0;
      out_found     <= 1'b0;
      out_first_pos <= '0;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A pattern written on the accept edge is already in place for k=0.
          if (cfg_we) pattern <= cfg_seq;
          if (in_valid) begin
            word          <= in_data;
            bit_idx       <= '0;
            out_count     <= '0;
            out_found     <= 1'b0;
            out_first_pos <= '0;
            busy          <= 1'b1;
            state         <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            word <= {word[W-2:0], 1'b0};
            if (match) begin
              out_count <= out_count + CW'(1);
              out_found <= 1'b1;
              if (!out_found) out_first_pos <= bit_idx;
            end
            if (bit_idx == LAST_IDX) begin
              out_valid <= 1'b1;
              state     <= REPORT;
            end else begin
              bit_idx <= bit_idx + PW'(1);
            end
          end
        end
        REPORT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
Controller that sequences a serial pattern-match datapath over parallel words. It accepts a W-bit word through a valid/ready handshake and shifts it MSB-first, one bit per clock, through an N-bit shift-and-compare stage. It counts every (overlapping) occurrence of a programmable N-bit pattern and returns the count, a found flag and the position of the first match through a second valid/ready handshake. It sits between a word-oriented producer/consumer and the bit-serial detector, and owns detector clearing, pattern configuration and fill qualification.

Parameters:
N, 6, pattern width in bits (N >= 2, N <= W)
W, 32, input word width in bits
CW, $clog2(W+1), width of match counter
PW, $clog2(W), width of bit-position fields

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
cfg_we  in  1  pattern write strobe, honoured only in IDLE
cfg_seq  in  N  pattern; cfg_seq[N-1] is the earliest bit in time
in_valid  in  1  input word valid
in_ready  out  1  controller can accept a word
in_data  in  W  word, scanned from in_data[W-1] down to in_data[0]
abort  in  1  cancel scan in progress, no result produced
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_count  out  CW  number of matches in word
out_found  out  1  out_count != 0
out_first_pos  out  PW  bit index k (0 = MSB) at which the first match completed; 0 if none
busy  out  1  high in SHIFT and REPORT

Behaviour:
- Reset and clock: reset reset_n, asynchronous, active-low; clock clk.
- Reset values: state IDLE, pattern register 0, history 0, fill counter 0, bit index 0, out_count 0, out_found 0, out_first_pos 0, out_valid 0, busy 0. in_ready = (state==IDLE) and reads 1 during reset; handshakes are ignored while reset_n is low.
- States are IDLE, SHIFT and REPORT.
- IDLE:
  - in_ready=1.
  - cfg_we latches cfg_seq on the edge.
  - in_valid&in_ready latches in_data, clears history/fill/count/first_pos/bit index, and enters SHIFT.
  - If cfg_we and the accept occur on the same edge, the new pattern applies to that word.
- SHIFT (W cycles, k = 0..W-1):
  - Each edge shifts in bit in_data[W-1-k]: history_next = {history[N-2:0], bit}.
  - Match at k when k >= N-1 and history_next == pattern. Compare is on the next history, so the count updates on the same edge as the shift.
  - Fill qualification: bits from before the word (cleared zeros) never produce a match. An all-zero pattern therefore cannot match before k = N-1.
  - On a match: count += 1. If this is the first match, first_pos = k.
  - No saturation is needed, since max count = W-N+1.
  - cfg_we is ignored.
  - abort → IDLE on the next edge, with no result and outputs unchanged.
  - On the edge shifting k = W-1 → REPORT.
- REPORT:
  - out_valid=1, in_ready=0. Outputs stay stable until accepted.
  - out_valid&out_ready → IDLE. The next word can be accepted one cycle later, not on the same edge.
  - abort is ignored; cfg_we is ignored.
- Latency: out_valid rises W edges after the accepting edge. Throughput is one word per W+2 cycles at best.
- Reset asserted mid-SHIFT or mid-REPORT: immediate return to reset values. The partial result is discarded, and the pattern reverts to 0.

Decomposition:
- Package seq_scan_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, REPORT} scan_state_t
  - localparam helpers for CW/PW
- Sub-module seq_shift_match(N) contains the N-bit history shift register, the synchronous clear, and a saturating fill counter up to N. It outputs a qualified combinational match on the next history. The controller instantiates one of these.

Test Plan:
(N=3, W=8)
- Basic and non-overlap: cfg_seq=3'b101, word 8'b10101101 → after 8 shift cycles out_valid=1, out_count=3, out_found=1, out_first_pos=2.
- Overlap and zero-pattern fill guard: cfg_seq=3'b111, word 8'hFF → count 6, first_pos 2. cfg_seq=3'b000, word 8'h1F → count 1, first_pos 2.
- No match: cfg_seq=3'b110, word 8'h00 → count 0, out_found 0, first_pos 0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → out_valid held and outputs stable, in_ready=0, no second word accepted. Release → IDLE, then the second word is accepted on the next cycle.
- Same-edge config: cfg_we=1 with cfg_seq=3'b011 on the accept edge, word 8'h33 → count 2, first_pos 3. cfg_we during SHIFT does not change the result.
- Abort/reset: abort at k=4 → IDLE with no out_valid. reset_n low during SHIFT → all outputs 0, pattern 0, in_ready 1 after release.
